// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 2W-bit ops through a W-bit ALU in two passes (low word, then high word) and owns NZCV.
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_op/req_s/req_a/req_b : request handshake and operands
//   resp_valid/resp_ready/resp_result             : result handshake
//   status_nzcv                                   : {N,Z,C,V} status register
//   alu_exe_cmd/alu_val1/alu_val2/alu_c_in        : ALU drive while busy
//   alu_result/alu_c_out                          : combinational ALU response
module alu_wide_sequencer #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_op,
    input  logic           req_s,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [2*W-1:0] resp_result,
    output logic [3:0]     status_nzcv,
    output logic [3:0]     alu_exe_cmd,
    output logic [W-1:0]   alu_val1,
    output logic [W-1:0]   alu_val2,
    output logic           alu_c_in,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_c_out
);
    localparam logic [2:0] OP_MOV = 3'b000, OP_MVN = 3'b001, OP_ADD = 3'b010, OP_ADC = 3'b011,
                           OP_SUB = 3'b100, OP_AND = 3'b101, OP_ORR = 3'b110;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic           s_q, s_d, c_lo_q, c_lo_d;
    logic [2*W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]     nzcv_q, nzcv_d;
    logic           arith, is_sub, hi, a_msb, r_msb, v;
    logic [3:0]     cmd;
    logic [W-1:0]   a_w, b_w;
    always_comb begin
        arith  = (op_q == OP_ADD) || (op_q == OP_ADC) || (op_q == OP_SUB);
        is_sub = op_q == OP_SUB;
        hi     = state_q == HI;
        cmd    = arith ? 4'b0011 : op_q == OP_MOV ? 4'b0001 : op_q == OP_MVN ? 4'b1001 :
                 op_q == OP_AND ? 4'b0110 : op_q == OP_ORR ? 4'b0111 : 4'b1000;
        a_w    = hi ? a_q[2*W-1:W] : a_q[W-1:0];
        b_w    = hi ? b_q[2*W-1:W] : b_q[W-1:0];
        a_msb  = a_q[2*W-1];
        r_msb  = alu_result[W-1];
        // Subtraction overflows when operand signs differ; addition when they match.
        v      = (is_sub ? (a_msb != b_q[2*W-1]) : (a_msb == b_q[2*W-1])) && (r_msb != a_msb);
        state_d     = state_q;
        op_d        = op_q;
        s_d         = s_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        c_lo_d      = c_lo_q;
        nzcv_d      = nzcv_q;
        alu_exe_cmd = 4'b0000;
        alu_val1    = '0;
        alu_val2    = '0;
        alu_c_in    = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = req_op;
                s_d     = req_s;
                a_d     = req_a;
                b_d     = req_b;
                state_d = LO;
            end
            LO: begin
                alu_exe_cmd      = cmd;
                alu_val1         = a_w;
                alu_val2         = is_sub ? ~b_w : b_w;
                alu_c_in         = is_sub || (op_q == OP_ADC && nzcv_q[1]);
                result_d[W-1:0]  = alu_result;
                c_lo_d           = alu_c_out;
                state_d          = HI;
            end
            HI: begin
                alu_exe_cmd        = cmd;
                alu_val1           = a_w;
                alu_val2           = is_sub ? ~b_w : b_w;
                alu_c_in           = arith && c_lo_q;
                result_d[2*W-1:W]  = alu_result;
                state_d            = DONE;
                if (s_q)
                    nzcv_d = {r_msb, {alu_result, result_q[W-1:0]} == '0,
                              arith ? alu_c_out : nzcv_q[1], arith ? v : nzcv_q[0]};
            end
            default: if (resp_ready) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            s_q      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_lo_q   <= 1'b0;
            nzcv_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            s_q      <= s_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            c_lo_q   <= c_lo_d;
            nzcv_q   <= nzcv_d;
        end
    end
    assign req_ready   = state_q == IDLE;
    assign resp_valid  = state_q == DONE;
    assign resp_result = result_q;
    assign status_nzcv = nzcv_q;
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: scoreboard bench for alu_wide_sequencer with a 32-bit ALU model and a 64-bit reference model.
module tb_alu_wide_sequencer;
    logic        clk = 0, rst = 0;
    logic        req_valid = 0, req_ready, req_s = 0, resp_valid, resp_ready = 0, alu_c_in, alu_c_out;
    logic [2:0]  req_op = 0;
    logic [63:0] req_a = 0, req_b = 0, resp_result;
    logic [3:0]  status_nzcv, alu_exe_cmd;
    logic [31:0] alu_val1, alu_val2, alu_result;
    int          errors = 0, checks = 0;
    logic [67:0] sb[$];
    logic [3:0]  m_nzcv = 0;

    alu_wide_sequencer #(.W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_s(req_s), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .status_nzcv(status_nzcv), .alu_exe_cmd(alu_exe_cmd),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_c_in(alu_c_in),
        .alu_result(alu_result), .alu_c_out(alu_c_out)
    );

    always #5 clk = ~clk;

    // Execute-stage ALU: only the commands the sequencer may issue.
    always_comb begin
        {alu_c_out, alu_result} = 33'd0;
        case (alu_exe_cmd)
            4'b0001: alu_result = alu_val2;
            4'b1001: alu_result = ~alu_val2;
            4'b0011: {alu_c_out, alu_result} = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'd0, alu_c_in};
            4'b0110: alu_result = alu_val1 & alu_val2;
            4'b0111: alu_result = alu_val1 | alu_val2;
            4'b1000: alu_result = alu_val1 ^ alu_val2;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-word reference: returns {nzcv_after, result}.
    function automatic logic [67:0] model(input logic [2:0] op, input logic s, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] t;
        logic [63:0] r;
        logic        c, v;
        c = m_nzcv[1];
        v = m_nzcv[0];
        case (op)
            3'd0: r = b;
            3'd1: r = ~b;
            3'd2: begin t = {1'b0, a} + {1'b0, b}; r = t[63:0]; c = t[64]; end
            3'd3: begin t = {1'b0, a} + {1'b0, b} + {64'd0, m_nzcv[1]}; r = t[63:0]; c = t[64]; end
            3'd4: begin r = a - b; c = a >= b; end
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = a ^ b;
        endcase
        if (op inside {3'd2, 3'd3}) v = (a[63] == b[63]) && (r[63] != a[63]);
        if (op == 3'd4) v = (a[63] != b[63]) && (r[63] != a[63]);
        return {s ? {r[63], r == 64'd0, c, v} : m_nzcv, r};
    endfunction

    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) chk("unexpected_response", resp_result, 64'hX);
            else begin
                logic [67:0] e;
                e = sb.pop_front();
                chk("sb_result", resp_result, e[63:0]);
                chk("sb_nzcv", {60'd0, status_nzcv}, {60'd0, e[67:64]});
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic s, input logic [63:0] a, input logic [63:0] b,
                         input int hold, input logic chk_c, input logic [63:0] exp_r, input logic [3:0] exp_f);
        logic [67:0] e;
        logic [63:0] held;
        int edges;
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1; req_op = op; req_s = s; req_a = a; req_b = b;
        e = model(op, s, a, b);
        m_nzcv = e[67:64];
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 0;
        edges = 1;
        do begin
            @(posedge clk);
            #1 edges++;
        end while (!resp_valid && edges < 10);
        chk("latency_edges", edges, 3);
        held = resp_result;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_result", resp_result, held);
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
            chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
        end
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
        if (chk_c) begin
            chk("directed_result", held, exp_r);
            chk("directed_nzcv", {60'd0, status_nzcv}, {60'd0, exp_f});
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return {32'd0, $urandom()} | 64'h0000_0000_FFFF_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_resp_result"}, resp_result, 64'd0);
        chk({tag, "_nzcv"}, {60'd0, status_nzcv}, 64'd0);
        chk({tag, "_alu"}, {alu_exe_cmd, alu_val1, alu_val2[26:0], alu_c_in}, 64'd0);
    endtask

    initial begin
        #12 reset_outputs("reset");
        @(negedge clk) rst = 1;
        do_op(3'd2, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1, 64'h0000_0001_0000_0000, 4'b0000);
        do_op(3'd2, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 64'h8000_0000_0000_0000, 4'b1001);
        do_op(3'd4, 1, 64'd5, 64'd5, 0, 1, 64'd0, 4'b0110);
        do_op(3'd4, 1, 64'd0, 64'd1, 0, 1, '1, 4'b1000);
        do_op(3'd4, 1, 64'd5, 64'd5, 0, 1, 64'd0, 4'b0110);
        do_op(3'd3, 0, 64'd1, 64'd1, 1, 1, 64'd3, 4'b0110);
        do_op(3'd4, 1, 64'h8000_0000_0000_0000, 64'd1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        do_op(3'd7, 1, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 5, 1, 64'd0, 4'b0111);
        // Abort an ADD while its high-word pass is on the ALU.
        @(negedge clk);
        req_valid = 1; req_op = 3'd2; req_s = 1; req_a = 64'h1234; req_b = 64'h5678;
        @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk);
        #2 rst = 0;
        #1 reset_outputs("abort");
        m_nzcv = 0;
        @(negedge clk) rst = 1;
        do_op(3'd2, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1, 64'h0000_0001_0000_0000, 4'b0000);
        for (int i = 0; i < 60; i++)
            do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(),
                  $urandom_range(0, 2), 0, 64'd0, 4'd0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
